// File: rtl/sys_act.sv
// Serial-to-parallel activation stage: bias add, ReLU, requantise and pack one frame per vector.
// Optional build macro ROUND_NEAREST_EN selects round-half-up instead of a truncating shift.
module sys_act #(
  parameter int unsigned BitSize     = 8,
  parameter int unsigned OutBitSize  = 4,
  parameter int unsigned NumOfNerves = 4,
  parameter int unsigned Shift       = 2,
  parameter int unsigned DepthOut    = 2
) (
  input  logic                                       clk,
  input  logic                                       res,
  input  logic                                       in_valid,
  input  logic                                       in_start,
  input  logic [BitSize-1:0]                         in_data,
  input  logic [NumOfNerves-1:0][BitSize-1:0]        bias,
  output logic                                       out_valid,
  output logic                                       out_start,
  output logic [NumOfNerves-1:0][OutBitSize-1:0]     out_data,
  output logic                                       frame_err
);

  localparam int unsigned IdxW = (NumOfNerves > 1) ? $clog2(NumOfNerves) : 1;
  localparam int unsigned CntW = (DepthOut > 1) ? $clog2(DepthOut) : 1;
  localparam logic [BitSize:0] OutMax = (BitSize + 1)'((1 << OutBitSize) - 1);
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(NumOfNerves - 1);
  localparam logic [CntW-1:0]  LastCnt = CntW'(DepthOut - 1);
`ifdef ROUND_NEAREST_EN
  localparam logic [BitSize:0] RoundAdd = (Shift > 0) ? (BitSize + 1)'(1 << (Shift - 1)) : '0;
`endif

  typedef enum logic [0:0] {StIdle, StCollect} state_e;

  state_e                                  state_q, state_d;
  logic [IdxW-1:0]                         idx_q, idx_d;
  logic [CntW-1:0]                         cnt_q, cnt_d;
  logic [NumOfNerves-1:0][OutBitSize-1:0]  shadow_q, shadow_d;
  logic [NumOfNerves-1:0][OutBitSize-1:0]  out_data_q, out_data_d;
  logic                                    out_valid_q, out_valid_d;
  logic                                    out_start_q, out_start_d;
  logic                                    frame_err_q, frame_err_d;

  logic [IdxW-1:0]        elem_idx;
  logic [IdxW-1:0]        lane;
  logic signed [BitSize:0] sum;
  logic [BitSize:0]       relu;
  logic [BitSize:0]       rnd;
  logic [BitSize:0]       shifted;
  logic [OutBitSize-1:0]  lane_val;

  // Datapath for the element presented this cycle; a start always maps to element 0.
  always_comb begin
    elem_idx = (state_q == StIdle || in_start) ? '0 : idx_q;
    lane     = LastIdx - elem_idx;
    sum      = $signed({in_data[BitSize-1], in_data}) + $signed({bias[lane][BitSize-1], bias[lane]});
    relu     = sum[BitSize] ? '0 : $unsigned(sum);
`ifdef ROUND_NEAREST_EN
    rnd      = relu + RoundAdd;
`else
    rnd      = relu;
`endif
    shifted  = rnd >> Shift;
    lane_val = (shifted > OutMax) ? '1 : shifted[OutBitSize-1:0];
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_start_d = 1'b0;
    frame_err_d = 1'b0;
    if (in_valid) begin
      if (state_q == StIdle && !in_start) begin
        frame_err_d = 1'b1;
      end else begin
        if (state_q == StCollect && in_start) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
        end
        shadow_d[lane] = lane_val;
        if (elem_idx == LastIdx) begin
          out_data_d  = shadow_d;
          out_valid_d = 1'b1;
          out_start_d = (cnt_d == '0);
          cnt_d       = (cnt_d == LastCnt) ? '0 : cnt_d + 1'b1;
          state_d     = StIdle;
          idx_d       = '0;
        end else begin
          idx_d   = elem_idx + 1'b1;
          state_d = StCollect;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_start_q <= out_start_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_start = out_start_q;
  assign out_data  = out_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sys_act.sv
// Bench for sys_act: directed scenarios plus random traffic against a queue-based frame model.
module tb_sys_act;

  localparam int BitSize = 8;
  localparam int OutBitSize = 4;
  localparam int NumOfNerves = 4;
  localparam int Shift = 2;
  localparam int DepthOut = 2;
  localparam int OutMax = (1 << OutBitSize) - 1;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic in_valid = 1'b0;
  logic in_start = 1'b0;
  logic [BitSize-1:0] in_data = '0;
  logic [NumOfNerves-1:0][BitSize-1:0] bias = '0;
  logic out_valid;
  logic out_start;
  logic [NumOfNerves-1:0][OutBitSize-1:0] out_data;
  logic frame_err;

  sys_act #(
    .BitSize(BitSize), .OutBitSize(OutBitSize), .NumOfNerves(NumOfNerves),
    .Shift(Shift), .DepthOut(DepthOut)
  ) dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_start(in_start), .in_data(in_data),
    .bias(bias), .out_valid(out_valid), .out_start(out_start), .out_data(out_data),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  // Model state: lane values of the frame collected so far, and vectors since group start.
  int frame[$];
  int mcnt = 0;
  logic exp_valid = 1'b0;
  logic exp_start = 1'b0;
  logic exp_err = 1'b0;
  logic [NumOfNerves-1:0][OutBitSize-1:0] exp_data = '0;
  logic [NumOfNerves*OutBitSize-1:0] lit;

  function automatic int act(input logic [BitSize-1:0] d, input logic [BitSize-1:0] b);
    int r;
    r = int'($signed(d)) + int'($signed(b));
    if (r < 0) r = 0;
`ifdef ROUND_NEAREST_EN
    if (Shift > 0) r = r + (1 << (Shift - 1));
`endif
    r = r / (1 << Shift);
    if (r > OutMax) r = OutMax;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: apply inputs, advance the model, then compare all outputs after the edge.
  task automatic cycle(input logic r, input logic v, input logic s, input logic [BitSize-1:0] d);
    res = r; in_valid = v; in_start = s; in_data = d;
    exp_valid = 1'b0; exp_start = 1'b0; exp_err = 1'b0;
    if (r) begin
      frame.delete();
      mcnt = 0;
      exp_data = '0;
    end else if (v) begin
      if (s) begin
        if (frame.size() != 0) begin
          exp_err = 1'b1;
          mcnt = 0;
        end
        frame.delete();
        frame.push_back(act(d, bias[NumOfNerves-1]));
      end else if (frame.size() == 0) begin
        exp_err = 1'b1;
      end else begin
        frame.push_back(act(d, bias[NumOfNerves-1-frame.size()]));
      end
      if (frame.size() == NumOfNerves) begin
        for (int k = 0; k < NumOfNerves; k++) exp_data[NumOfNerves-1-k] = OutBitSize'(frame[k]);
        exp_valid = 1'b1;
        exp_start = (mcnt == 0);
        mcnt = (mcnt + 1) % DepthOut;
        frame.delete();
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("out_start", 64'(out_start), 64'(exp_start));
    chk("frame_err", 64'(frame_err), 64'(exp_err));
    chk("out_data", 64'(out_data), 64'(exp_data));
  endtask

  task automatic gaps(input int maxg);
    int n;
    n = $urandom_range(0, maxg);
    for (int g = 0; g < n; g++) cycle(1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  initial begin
    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 8'd0);
    cycle(1'b1, 1'b0, 1'b0, 8'd0);
    chk("rst_data", 64'(out_data), 64'd0);

    // Basic frame, bias 0
    bias = '0;
    cycle(1'b0, 1'b1, 1'b1, 8'd40);
    cycle(1'b0, 1'b1, 1'b0, 8'd20);
    cycle(1'b0, 1'b1, 1'b0, 8'd8);
    cycle(1'b0, 1'b1, 1'b0, -8'sd4);
    lit = 16'hA520;
    chk("t2_data", 64'(out_data), 64'(lit));
    chk("t2_valid", 64'(out_valid), 64'd1);
    chk("t2_start", 64'(out_start), 64'd1);
    // Same frame with random gaps
    cycle(1'b0, 1'b1, 1'b1, 8'd40); gaps(3);
    cycle(1'b0, 1'b1, 1'b0, 8'd20); gaps(3);
    cycle(1'b0, 1'b1, 1'b0, 8'd8);  gaps(3);
    cycle(1'b0, 1'b1, 1'b0, -8'sd4);
    chk("t2g_data", 64'(out_data), 64'(lit));
    chk("t2g_valid", 64'(out_valid), 64'd1);

    // Saturation and ReLU
    bias = '0; bias[0] = -8'sd10;
    cycle(1'b0, 1'b1, 1'b1, 8'd100);
    cycle(1'b0, 1'b1, 1'b0, 8'd127);
    cycle(1'b0, 1'b1, 1'b0, -8'sd128);
    cycle(1'b0, 1'b1, 1'b0, 8'd5);
    lit = 16'hFF00;
    chk("t3_sat", 64'(out_data), 64'(lit));
    bias = '0; bias[3] = -8'sd128;
    cycle(1'b0, 1'b1, 1'b1, -8'sd128);
    cycle(1'b0, 1'b1, 1'b0, 8'd4);
    cycle(1'b0, 1'b1, 1'b0, 8'd8);
    cycle(1'b0, 1'b1, 1'b0, 8'd12);
    lit = 16'h0123;
    chk("t3_nowrap", 64'(out_data), 64'(lit));

    // Reset mid-frame for 3 cycles
    bias = '0;
    cycle(1'b0, 1'b1, 1'b1, 8'd33);
    cycle(1'b0, 1'b1, 1'b0, 8'd44);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 8'd9);
    chk("t1_data", 64'(out_data), 64'd0);

    // Three back-to-back frames: out_start 1,0,1
    for (int f = 0; f < 3; f++) begin
      for (int e = 0; e < NumOfNerves; e++) cycle(1'b0, 1'b1, e == 0, 8'($urandom_range(0, 120)));
      chk("t4_start", 64'(out_start), 64'(f != 1));
    end
    cycle(1'b0, 1'b0, 1'b0, 8'd0);

    // Restart mid-frame, then a stray element in idle
    cycle(1'b0, 1'b1, 1'b1, 8'd16);
    cycle(1'b0, 1'b1, 1'b0, 8'd16);
    cycle(1'b0, 1'b1, 1'b1, 8'd4);
    chk("t5_err", 64'(frame_err), 64'd1);
    cycle(1'b0, 1'b1, 1'b0, 8'd8);
    cycle(1'b0, 1'b1, 1'b0, 8'd12);
    cycle(1'b0, 1'b1, 1'b0, 8'd16);
    chk("t5_start", 64'(out_start), 64'd1);
    lit = 16'h1234;
    chk("t5_data", 64'(out_data), 64'(lit));
    cycle(1'b0, 1'b1, 1'b0, 8'd50);
    chk("t5_lone", 64'(frame_err), 64'd1);

    // Rounding boundary
    cycle(1'b0, 1'b1, 1'b1, 8'd6);
    cycle(1'b0, 1'b1, 1'b0, 8'd63);
    cycle(1'b0, 1'b1, 1'b0, 8'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'd0);
`ifdef ROUND_NEAREST_EN
    lit = 16'h2F00;
`else
    lit = 16'h1F00;
`endif
    chk("t6_round", 64'(out_data), 64'(lit));

    // Random traffic with random biases
    for (int l = 0; l < NumOfNerves; l++) bias[l] = 8'($urandom);
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 6) == 0), 8'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
